// File: rtl/i2s_receiver_pkg.sv
// Shared I2S timing defaults and word-select polarity used by the receive and transmit paths.
package i2s_receiver_pkg;

    localparam int unsigned SCLK_WS_RATIO_DEF   = 64;
    localparam int unsigned MCLK_SCLK_RATIO_DEF = 4;
    localparam int unsigned D_WIDTH_DEF         = 24;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_receiver_clkgen.sv
// Derives sclk and ws from mclk; exposes the sclk rising-edge strobe and position within the ws half-period.
module i2s_receiver_clkgen
    import i2s_receiver_pkg::*;
#(
    parameter int unsigned SCLK_WS_RATIO   = SCLK_WS_RATIO_DEF,
    parameter int unsigned MCLK_SCLK_RATIO = MCLK_SCLK_RATIO_DEF,
    parameter int unsigned WS_CNT_W        = cnt_width(SCLK_WS_RATIO)
) (
    input  logic                mclk,
    input  logic                reset_n,
    output logic                sclk,
    output logic                ws,
    output logic                sclk_rise_c,
    output logic [WS_CNT_W-1:0] ws_cnt
);

    localparam int unsigned             HALF    = MCLK_SCLK_RATIO / 2;
    localparam int unsigned             MC_W    = cnt_width(HALF);
    localparam logic [MC_W-1:0]         MC_LAST = MC_W'(HALF - 1);
    localparam logic [WS_CNT_W-1:0]     WS_LAST = WS_CNT_W'(SCLK_WS_RATIO - 1);

    logic [MC_W-1:0] mclk_cnt;
    logic            toggle_c;

    assign toggle_c    = (mclk_cnt == MC_LAST);
    // Toggles issued from an even ws_cnt drive sclk high.
    assign sclk_rise_c = toggle_c && !ws_cnt[0];

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            mclk_cnt <= '0;
            sclk     <= 1'b0;
            ws       <= WS_LEFT;
            ws_cnt   <= '0;
        end else begin
            mclk_cnt <= toggle_c ? '0 : mclk_cnt + MC_W'(1);
            if (toggle_c) begin
                sclk <= ~sclk;
                if (ws_cnt == WS_LAST) begin
                    ws_cnt <= '0;
                    ws     <= ~ws;
                end else begin
                    ws_cnt <= ws_cnt + WS_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S capture master: generates sclk/ws, deserialises MSB-first stereo samples and presents each L/R pair with a one-cycle strobe.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int unsigned sclk_ws_ratio   = SCLK_WS_RATIO_DEF,
    parameter int unsigned mclk_sclk_ratio = MCLK_SCLK_RATIO_DEF,
    parameter int unsigned d_width         = D_WIDTH_DEF
) (
    input  logic               mclk,
    input  logic               reset_n,
    output logic               sclk,
    output logic               ws,
    input  logic               sd_rx,
    output logic [d_width-1:0] l_data_rx,
    output logic [d_width-1:0] r_data_rx,
    output logic               rx_valid
);

    localparam int unsigned         WS_CNT_W     = cnt_width(sclk_ws_ratio);
    localparam logic [WS_CNT_W-1:0] LAST_BIT_CNT = WS_CNT_W'(2 * d_width);

    logic                sclk_rise_c;
    logic [WS_CNT_W-1:0] ws_cnt;
    logic [d_width-1:0]  shreg;
    logic [d_width-1:0]  left_hold;
    logic [d_width-1:0]  word_c;
    logic                data_bit_c;
    logic                word_done_c;

    i2s_receiver_clkgen #(
        .SCLK_WS_RATIO   (sclk_ws_ratio),
        .MCLK_SCLK_RATIO (mclk_sclk_ratio),
        .WS_CNT_W        (WS_CNT_W)
    ) u_clkgen (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .ws          (ws),
        .sclk_rise_c (sclk_rise_c),
        .ws_cnt      (ws_cnt)
    );

    // Rise at ws_cnt=0 is the I2S delay slot; rises past the last data bit are padding.
    assign data_bit_c  = sclk_rise_c && (ws_cnt != '0) && (ws_cnt <= LAST_BIT_CNT);
    assign word_done_c = sclk_rise_c && (ws_cnt == LAST_BIT_CNT);
    assign word_c      = {shreg[d_width-2:0], sd_rx};

    // Left word is parked until its right partner completes so the pair updates atomically.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            left_hold <= '0;
            l_data_rx <= '0;
            r_data_rx <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (data_bit_c) begin
                shreg <= word_c;
            end
            if (word_done_c) begin
                if (ws == WS_LEFT) begin
                    left_hold <= word_c;
                end else begin
                    l_data_rx <= left_hold;
                    r_data_rx <= word_c;
                    rx_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: ADC model and per-cycle frame-arithmetic reference for two parameter sets.
module tb_i2s_receiver;

    localparam int SW = 64;
    localparam int RA = 4;
    localparam int DA = 24;
    localparam int RB = 8;
    localparam int DB = 16;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sd_a = 1'b0;
    logic        sd_b = 1'b0;
    logic        sclk_a, ws_a, v_a;
    logic        sclk_b, ws_b, v_b;
    logic [23:0] l_a, r_a;
    logic [15:0] l_b, r_b;

    int checks = 0;
    int failures = 0;
    int seg = 0;
    bit pad_one = 1'b0;
    int n = 0;

    logic [23:0] fl_a [0:127];
    logic [23:0] fr_a [0:127];
    logic [15:0] fl_b [0:127];
    logic [15:0] fr_b [0:127];

    logic [23:0] exp_l_a = '0, exp_r_a = '0;
    logic [15:0] exp_l_b = '0, exp_r_b = '0;

    i2s_receiver dut_a (
        .mclk(mclk), .reset_n(reset_n), .sclk(sclk_a), .ws(ws_a), .sd_rx(sd_a),
        .l_data_rx(l_a), .r_data_rx(r_a), .rx_valid(v_a)
    );

    i2s_receiver #(.sclk_ws_ratio(SW), .mclk_sclk_ratio(RB), .d_width(DB)) dut_b (
        .mclk(mclk), .reset_n(reset_n), .sclk(sclk_b), .ws(ws_b), .sd_rx(sd_b),
        .l_data_rx(l_b), .r_data_rx(r_b), .rx_valid(v_b)
    );

    always #5 mclk = ~mclk;

    // mclk edges since reset release
    always @(posedge mclk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // After edge nn: which ws half (h) and bit slot (j, 1=MSB) the next sclk rise belongs to.
    function automatic void next_slot(input int nn, input int r, output int h, output int j);
        int t, k;
        t = nn / (r / 2);
        k = (t % 2 == 0) ? t + 1 : t + 2;
        h = (k - 1) / SW;
        j = ((k - 1) % SW) / 2;
    endfunction

    // The right word of a frame completes on the rise at ws_cnt=2d of the right half.
    function automatic bit pulse_at(input int nn, input int r, input int d);
        return (nn > 0) && ((nn % (SW * r)) == ((2 * d + 1 + SW) * r / 2));
    endfunction

    function automatic int fidx(input int s, input int m);
        return (s * 16 + m) & 127;
    endfunction

    // ADC model: present the bit for the upcoming sclk rise
    always @(negedge mclk) begin : adc
        int h, j;
        logic [23:0] wa;
        logic [15:0] wb;
        next_slot(n, RA, h, j);
        if (j >= 1 && j <= DA) begin
            wa = (h % 2 == 0) ? fl_a[fidx(seg, h / 2)] : fr_a[fidx(seg, h / 2)];
            sd_a = wa[DA - j];
        end else begin
            sd_a = pad_one ? 1'b1 : 1'($urandom % 2);
        end
        next_slot(n, RB, h, j);
        if (j >= 1 && j <= DB) begin
            wb = (h % 2 == 0) ? fl_b[fidx(seg, h / 2)] : fr_b[fidx(seg, h / 2)];
            sd_b = wb[DB - j];
        end else begin
            sd_b = pad_one ? 1'b1 : 1'($urandom % 2);
        end
    end

    // Reference compare on every cycle
    always @(negedge mclk) begin : ref_cmp
        int ta, tb;
        bit pa, pb;
        if (!reset_n) begin
            exp_l_a = '0; exp_r_a = '0; exp_l_b = '0; exp_r_b = '0;
            ta = 0; tb = 0; pa = 0; pb = 0;
        end else begin
            ta = n / (RA / 2);
            tb = n / (RB / 2);
            pa = pulse_at(n, RA, DA);
            pb = pulse_at(n, RB, DB);
            if (pa) begin
                exp_l_a = fl_a[fidx(seg, n / (SW * RA))];
                exp_r_a = fr_a[fidx(seg, n / (SW * RA))];
            end
            if (pb) begin
                exp_l_b = fl_b[fidx(seg, n / (SW * RB))];
                exp_r_b = fr_b[fidx(seg, n / (SW * RB))];
            end
        end
        check("a_sclk", 32'(sclk_a), 32'(ta % 2));
        check("a_ws", 32'(ws_a), 32'((ta / SW) % 2));
        check("a_valid", 32'(v_a), 32'(pa));
        check("a_l", 32'(l_a), 32'(exp_l_a));
        check("a_r", 32'(r_a), 32'(exp_r_a));
        check("b_sclk", 32'(sclk_b), 32'(tb % 2));
        check("b_ws", 32'(ws_b), 32'((tb / SW) % 2));
        check("b_valid", 32'(v_b), 32'(pb));
        check("b_l", 32'(l_b), 32'(exp_l_b));
        check("b_r", 32'(r_b), 32'(exp_r_b));
    end

    task automatic fill(input int s, input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: begin fl_a[fidx(s, i)] = 24'h7FFFFF; fr_a[fidx(s, i)] = 24'h800000; end
                1: begin fl_a[fidx(s, i)] = 24'hA5A5A5; fr_a[fidx(s, i)] = 24'h5A5A5A; end
                default: begin
                    fl_a[fidx(s, i)] = 24'($urandom);
                    fr_a[fidx(s, i)] = 24'($urandom);
                end
            endcase
            if (mode == 2) begin
                fl_b[fidx(s, i)] = 16'($urandom);
                fr_b[fidx(s, i)] = 16'($urandom);
            end else begin
                fl_b[fidx(s, i)] = 16'h8001;
                fr_b[fidx(s, i)] = 16'h0001;
            end
        end
    endtask

    task automatic start_reset();
        @(posedge mclk);
        #3 reset_n = 1'b0;
    endtask

    task automatic release_reset(input int new_seg);
        seg = new_seg;
        repeat (3) @(posedge mclk);
        #2 reset_n = 1'b1;
    endtask

    task automatic wait_pulse(input bit use_b, input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge mclk);
            #1;
            cyc++;
        end while (((use_b ? v_b : v_a) !== 1'b1) && cyc < limit);
        if ((use_b ? v_b : v_a) !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL pulse_timeout: no rx_valid within %0d cycles (dut_%s)", limit, use_b ? "b" : "a");
        end
    endtask

    initial begin : watchdog
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        fill(0, 0);
        release_reset(0);

        // Asynchronous reset mid-frame after data has been captured
        wait_pulse(1'b0, 400, cyc);
        repeat (40) @(posedge mclk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_sclk", 32'(sclk_a), 32'h0);
        check("rst_ws", 32'(ws_a), 32'h0);
        check("rst_l", 32'(l_a), 32'h0);
        check("rst_r", 32'(r_a), 32'h0);
        check("rst_valid", 32'(v_a), 32'h0);
        fill(1, 0);
        release_reset(1);
        cyc = 0;
        do begin
            @(posedge mclk);
            #1;
            cyc++;
        end while (ws_a !== 1'b1 && cyc < 300);
        check("ws_first_rise", 32'(cyc), 32'd128);

        // Full-scale pair
        wait_pulse(1'b0, 400, cyc);
        check("maxmin_l", 32'(l_a), 32'h7FFFFF);
        check("maxmin_r", 32'(r_a), 32'h800000);
        wait_pulse(1'b0, 400, cyc);
        check("frame_period", 32'(cyc), 32'd256);

        // Alternating pattern with pad bits forced high
        start_reset();
        fill(2, 1);
        pad_one = 1'b1;
        release_reset(2);
        wait_pulse(1'b0, 400, cyc);
        check("first_pulse", 32'(cyc), 32'd226);
        check("alt_l", 32'(l_a), 32'hA5A5A5);
        check("alt_r", 32'(r_a), 32'h5A5A5A);
        pad_one = 1'b0;

        // Random stream
        start_reset();
        fill(3, 2);
        release_reset(3);
        for (int i = 0; i < 8; i++) begin
            wait_pulse(1'b0, 400, cyc);
            check("rand_l", 32'(l_a), 32'(fl_a[fidx(3, i)]));
            check("rand_r", 32'(r_a), 32'(fr_a[fidx(3, i)]));
            @(posedge mclk);
            #1;
            check("valid_width", 32'(v_a), 32'h0);
        end

        // Reset pulsed during right-channel bit 10
        cyc = 0;
        do begin
            @(posedge mclk);
            #1;
            cyc++;
        end while ((n % 256) != 168 && cyc < 400);
        fill(4, 2);
        start_reset();
        release_reset(4);
        wait_pulse(1'b0, 400, cyc);
        check("post_reset_pulse", 32'(cyc), 32'd226);
        check("post_reset_l", 32'(l_a), 32'(fl_a[fidx(4, 0)]));
        check("post_reset_r", 32'(r_a), 32'(fr_a[fidx(4, 0)]));

        // 8:1 mclk/sclk, 16-bit instance
        start_reset();
        fill(5, 0);
        release_reset(5);
        wait_pulse(1'b1, 800, cyc);
        check("b_first_pulse", 32'(cyc), 32'd388);
        check("b_l_lit", 32'(l_b), 32'h8001);
        check("b_r_lit", 32'(r_b), 32'h0001);
        wait_pulse(1'b1, 800, cyc);
        check("b_frame_period", 32'(cyc), 32'd512);

        repeat (4) @(posedge mclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
